// File: rtl/riscv_pkg.sv
// Shared RV64I pipeline definitions: widths, ALUOp classes and the decoded control bundle.
package riscv_pkg;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_RSVD   = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  // A bubble must never write state, touch memory or redirect the PC.
  localparam ctrl_t CTRL_BUBBLE = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    branch:     1'b0,
    alu_src:    1'b0,
    alu_op:     ALUOP_LDST
  };

endpackage

// File: rtl/hazard_detection_unit.sv
// Combinational load-use hazard detection; freezes PC and IF/ID on a stall or global hold.
module hazard_detection_unit
  import riscv_pkg::*;
(
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 hold,
  output logic                 stall,
  output logic                 pc_write,
  output logic                 if_id_write
);

  // Both sources are compared regardless of whether the instruction reads them.
  always_comb begin
    stall       = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if (ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
        ((ex_rd == id_rs1) || (ex_rd == id_rs2))) begin
      stall = 1'b1;
    end else begin
      stall = 1'b0;
    end
    pc_write    = ~(stall | hold);
    if_id_write = ~(stall | hold);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch-flush squash.
// Optional HAZARD_STATS_EN adds free-running StallCount / FlushCount outputs.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Hold,
  input  logic                 Flush,
  input  logic                 ID_Valid,
  input  logic [XLEN-1:0]      ID_PC,
  input  logic [REG_IDX_W-1:0] ID_RS1,
  input  logic [REG_IDX_W-1:0] ID_RS2,
  input  logic [REG_IDX_W-1:0] ID_Rd,
  input  logic [XLEN-1:0]      ID_ReadData1,
  input  logic [XLEN-1:0]      ID_ReadData2,
  input  logic [XLEN-1:0]      ID_Imm,
  input  logic [3:0]           ID_Funct4,
  input  logic                 ID_RegWrite,
  input  logic                 ID_MemRead,
  input  logic                 ID_MemWrite,
  input  logic                 ID_MemtoReg,
  input  logic                 ID_Branch,
  input  logic                 ID_ALUSrc,
  input  logic [1:0]           ID_ALUOp,
  output logic                 ID_EX_Valid,
  output logic [XLEN-1:0]      ID_EX_PC,
  output logic [REG_IDX_W-1:0] ID_EX_RS1,
  output logic [REG_IDX_W-1:0] ID_EX_RS2,
  output logic [REG_IDX_W-1:0] ID_EX_Rd,
  output logic [XLEN-1:0]      ID_EX_ReadData1,
  output logic [XLEN-1:0]      ID_EX_ReadData2,
  output logic [XLEN-1:0]      ID_EX_Imm,
  output logic [3:0]           ID_EX_Funct4,
  output logic                 ID_EX_RegWrite,
  output logic                 ID_EX_MemRead,
  output logic                 ID_EX_MemWrite,
  output logic                 ID_EX_MemtoReg,
  output logic                 ID_EX_Branch,
  output logic                 ID_EX_ALUSrc,
  output logic [1:0]           ID_EX_ALUOp,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic                 Stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]          StallCount,
  output logic [31:0]          FlushCount
`endif
);

  logic                 valid_r;
  logic [XLEN-1:0]      pc_r;
  logic [REG_IDX_W-1:0] rs1_r;
  logic [REG_IDX_W-1:0] rs2_r;
  logic [REG_IDX_W-1:0] rd_r;
  logic [XLEN-1:0]      rdata1_r;
  logic [XLEN-1:0]      rdata2_r;
  logic [XLEN-1:0]      imm_r;
  logic [3:0]           funct4_r;
  ctrl_t                ctrl_r;
  ctrl_t                ctrl_in_s;
  logic                 stall_s;
  logic                 bubble_s;

  hazard_detection_unit u_hdu (
    .ex_valid    (valid_r),
    .ex_mem_read (ctrl_r.mem_read),
    .ex_rd       (rd_r),
    .id_valid    (ID_Valid),
    .id_rs1      (ID_RS1),
    .id_rs2      (ID_RS2),
    .hold        (Hold),
    .stall       (stall_s),
    .pc_write    (PCWrite),
    .if_id_write (IF_ID_Write)
  );

  // Incoming control is squashed for an empty ID slot so it behaves like a bubble.
  always_comb begin
    ctrl_in_s = CTRL_BUBBLE;
    bubble_s  = Flush | stall_s;
    if (ID_Valid) begin
      ctrl_in_s.reg_write  = ID_RegWrite;
      ctrl_in_s.mem_read   = ID_MemRead;
      ctrl_in_s.mem_write  = ID_MemWrite;
      ctrl_in_s.mem_to_reg = ID_MemtoReg;
      ctrl_in_s.branch     = ID_Branch;
      ctrl_in_s.alu_src    = ID_ALUSrc;
      ctrl_in_s.alu_op     = alu_op_e'(ID_ALUOp);
    end else begin
      ctrl_in_s = CTRL_BUBBLE;
    end
  end

  // Pipeline register: reset, then hold, then bubble, then capture.
  always_ff @(posedge clk) begin
    if (reset || (!Hold && bubble_s)) begin
      valid_r  <= 1'b0;
      pc_r     <= '0;
      rs1_r    <= '0;
      rs2_r    <= '0;
      rd_r     <= '0;
      rdata1_r <= '0;
      rdata2_r <= '0;
      imm_r    <= '0;
      funct4_r <= 4'd0;
      ctrl_r   <= CTRL_BUBBLE;
    end else if (!Hold) begin
      valid_r  <= ID_Valid;
      pc_r     <= ID_PC;
      rs1_r    <= ID_RS1;
      rs2_r    <= ID_RS2;
      rd_r     <= ID_Rd;
      rdata1_r <= ID_ReadData1;
      rdata2_r <= ID_ReadData2;
      imm_r    <= ID_Imm;
      funct4_r <= ID_Funct4;
      ctrl_r   <= ctrl_in_s;
    end else begin
      valid_r  <= valid_r;
      ctrl_r   <= ctrl_r;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_r;
  logic [31:0] flush_count_r;

  // Flush wins attribution when both causes coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_r <= 32'd0;
      flush_count_r <= 32'd0;
    end else if (!Hold && Flush) begin
      flush_count_r <= flush_count_r + 32'd1;
    end else if (!Hold && stall_s) begin
      stall_count_r <= stall_count_r + 32'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign StallCount = stall_count_r;
  assign FlushCount = flush_count_r;
`endif

  assign Stall           = stall_s;
  assign ID_EX_Valid     = valid_r;
  assign ID_EX_PC        = pc_r;
  assign ID_EX_RS1       = rs1_r;
  assign ID_EX_RS2       = rs2_r;
  assign ID_EX_Rd        = rd_r;
  assign ID_EX_ReadData1 = rdata1_r;
  assign ID_EX_ReadData2 = rdata2_r;
  assign ID_EX_Imm       = imm_r;
  assign ID_EX_Funct4    = funct4_r;
  assign ID_EX_RegWrite  = ctrl_r.reg_write;
  assign ID_EX_MemRead   = ctrl_r.mem_read;
  assign ID_EX_MemWrite  = ctrl_r.mem_write;
  assign ID_EX_MemtoReg  = ctrl_r.mem_to_reg;
  assign ID_EX_Branch    = ctrl_r.branch;
  assign ID_EX_ALUSrc    = ctrl_r.alu_src;
  assign ID_EX_ALUOp     = ctrl_r.alu_op;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage RV64I core, with integrated load-use hazard detection. It captures decoded operands, register specifiers and control from the ID stage and presents them to the EX stage and the forwarding logic (ID_EX_RS1/RS2, ID_EX_Rd). On a load-use hazard it inserts a one-cycle bubble and freezes PC and IF/ID. On a taken-branch flush it squashes the instruction being captured.

## Interface
- XLEN, 64: datapath width.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- Hold  input  1  global pipeline freeze (data-memory not ready); all state holds.
- Flush  input  1  taken branch resolved in EX/MEM; squash the ID instruction.
- ID_Valid  input  1  ID stage holds a real instruction.
- ID_PC  input  XLEN  PC of the ID instruction.
- ID_RS1, ID_RS2, ID_Rd  input  5  register specifiers from IF/ID.
- ID_ReadData1, ID_ReadData2, ID_Imm  input  XLEN  register-file outputs and sign-extended immediate.
- ID_Funct4  input  4  {inst[30], inst[14:12]}.
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_Branch, ID_ALUSrc  input  1  decoded control.
- ID_ALUOp  input  2  decoded ALU class.
- ID_EX_* (Valid, PC, RS1, RS2, Rd, ReadData1, ReadData2, Imm, Funct4, RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp)  output  as inputs  registered copies.
- PCWrite  output  1  0 freezes the PC.
- IF_ID_Write  output  1  0 freezes IF/ID.
- Stall  output  1  load-use hazard detected this cycle.

## Operation
- Hazard (combinational): Stall = ID_EX_Valid & ID_EX_MemRead & (ID_EX_Rd != 0) & ID_Valid & ((ID_EX_Rd == ID_RS1) | (ID_EX_Rd == ID_RS2)). Both sources are compared unconditionally (conservative).
- PCWrite = IF_ID_Write = ~(Stall | Hold). Flush does not suppress them; the fetch unit redirects the PC.
- Register update priority on each edge:
  - reset → all zero.
  - Hold → keep.
  - Flush → bubble.
  - Stall → bubble.
  - otherwise → capture the ID_* inputs, with ID_EX_Valid = ID_Valid.
- Bubble: Valid, RegWrite, MemRead, MemWrite, MemtoReg and Branch are 0. ALUOp = 00. Data and specifier fields are zeroed, so Rd = 0 and the forwarding logic never matches a bubble.
- If ID_Valid = 0 on capture, the control bits are forced to 0, exactly as in a bubble.
- Flush together with Stall → bubble. IF_ID_Write stays 0 for that cycle.

## Timing
- All ID_EX_* outputs are registered with 1-cycle latency, and reset to 0.
- Stall, PCWrite and IF_ID_Write are combinational from the current ID_EX_* state and the ID_* inputs; there is no registered output path.
- A load-use stall lasts exactly one cycle, because the bubble clears ID_EX_MemRead. On the next cycle the same ID instruction is captured.
- Back-to-back loads with a dependency give one stall per dependent pair.
- Reset asserted mid-stall: the next edge zeroes everything, and Stall falls in that cycle.
- Hold during a pending hazard: Stall stays asserted and the state freezes. The bubble is inserted on the first non-Hold edge.

## Configuration
- HAZARD_STATS_EN defined:
  - adds outputs StallCount and FlushCount, 32 bits each, reset to 0;
  - each increments on an edge where Hold = 0 and a bubble is inserted for the respective cause;
  - Flush takes precedence when both Flush and Stall are present;
  - counts wrap at 2^32.
- Not defined: the outputs and counters are absent.

## Structure
- Shared package riscv_pkg:
  - ALUOp encodings (LDST = 00, BRANCH = 01, RTYPE = 10);
  - register-index width;
  - a control-bundle typedef (RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp) with a BUBBLE constant.
- One sub-module, hazard_detection_unit: purely combinational, produces Stall, PCWrite and IF_ID_Write.

## Test plan
- Load `ld x5,0(x1)` in ID_EX (MemRead=1, Rd=5), ID_RS1=5 → Stall=1, PCWrite=0, IF_ID_Write=0. Next cycle ID_EX_Valid=0, ID_EX_Rd=0. Following cycle the dependent instruction is captured with RS1=5.
- ID_EX Rd=0 with MemRead=1, ID_RS2=0 → Stall=0, normal capture.
- Flush=1 with a valid R-type (RegWrite=1, Rd=7) in ID → next ID_EX_Valid=0, RegWrite=0, Rd=0.
- Stall and Flush in the same cycle → bubble inserted. With HAZARD_STATS_EN, FlushCount+1 and StallCount unchanged.
- Hold=1 for 3 cycles with a pending hazard → outputs unchanged and Stall=1 throughout. On the first Hold=0 edge the bubble is inserted.
- reset=1 while ID_EX holds a load → next edge all ID_EX_* = 0, and PCWrite=1 in the following cycle.
